fft_addr_gen: RTL and testbench

- Control and address-generation stage that drives the radix-2 butterfly datapath for an in-place, decimation-in-time FFT.
- Walks all stages and butterflies of an N-point transform (N = 2^LOG2_N).
- Issues, per butterfly: sample-memory read addresses, the twiddle ROM index, the butterfly enable, and write-back addresses/enable.
- Sits between the sample RAM / twiddle ROM and the butterfly. Input samples are already in bit-reversed order in RAM before start.

---
 rtl/fft_addr_gen.sv | 182 ++++++++++++++++++
 tb/tb_fft_addr_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fft_addr_gen.sv
// Address and control sequencer for an in-place radix-2 DIT FFT.
// Walks every stage/butterfly, issues reads and twiddle index, and replays them as write-backs one cycle later.
module fft_addr_gen #(
    parameter int LOG2_N     = 9,
    parameter int ADDR_WIDTH = LOG2_N,
    parameter int TW_WIDTH   = LOG2_N - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      rd_addr_a,
    output logic [ADDR_WIDTH-1:0]      rd_addr_b,
    output logic [TW_WIDTH-1:0]        tw_addr,
    output logic                       rd_en,
    output logic                       bf_enable,
    output logic                       wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr_a,
    output logic [ADDR_WIDTH-1:0]      wr_addr_b,
    output logic [$clog2(LOG2_N)-1:0]  stage
);

    localparam int STAGE_W = $clog2(LOG2_N);
    localparam int I_W     = LOG2_N - 1;

    localparam logic [I_W-1:0]        I_LAST     = {I_W{1'b1}};
    localparam logic [STAGE_W-1:0]    S_LAST     = STAGE_W'(LOG2_N - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [TW_WIDTH-1:0]   TW_ZERO    = {TW_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [STAGE_W-1:0]   stage_r;
    logic [STAGE_W-1:0]   stage_nxt_s;
    logic [I_W-1:0]       idx_r;
    logic [I_W-1:0]       idx_nxt_s;
    logic                 run_nxt_s;

    logic                  busy_r;
    logic                  done_r;
    logic                  rd_en_r;
    logic [ADDR_WIDTH-1:0] rd_addr_a_r;
    logic [ADDR_WIDTH-1:0] rd_addr_b_r;
    logic [TW_WIDTH-1:0]   tw_addr_r;
    logic                  wr_en_r;
    logic                  bf_enable_r;
    logic [ADDR_WIDTH-1:0] wr_addr_a_r;
    logic [ADDR_WIDTH-1:0] wr_addr_b_r;

    // Upper index bits move up one position to open the gap for the B partner at bit s.
    function automatic logic [ADDR_WIDTH-1:0] calc_addr_a(input logic [I_W-1:0] idx,
                                                          input logic [STAGE_W-1:0] stg);
        logic [ADDR_WIDTH-1:0] idx_w;
        logic [ADDR_WIDTH-1:0] mask;
        idx_w = ADDR_WIDTH'(idx);
        mask  = (ADDR_WIDTH'(1) << stg) - ADDR_WIDTH'(1);
        return ((idx_w & ~mask) << 1) | (idx_w & mask);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] calc_addr_b(input logic [ADDR_WIDTH-1:0] addr_a,
                                                          input logic [STAGE_W-1:0] stg);
        return addr_a | (ADDR_WIDTH'(1) << stg);
    endfunction

    // In the last stage 1<<s overflows the mask width, leaving all ones as intended.
    function automatic logic [TW_WIDTH-1:0] calc_tw(input logic [I_W-1:0] idx,
                                                    input logic [STAGE_W-1:0] stg);
        logic [TW_WIDTH-1:0] mask;
        logic [STAGE_W-1:0]  shamt;
        mask  = (TW_WIDTH'(1) << stg) - TW_WIDTH'(1);
        shamt = S_LAST - stg;
        return (TW_WIDTH'(idx) & mask) << shamt;
    endfunction

    // Sequencer state, stage and butterfly counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            stage_r <= {STAGE_W{1'b0}};
            idx_r   <= {I_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            stage_r <= stage_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_nxt_s = state_r;
        stage_nxt_s = stage_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    stage_nxt_s = {STAGE_W{1'b0}};
                    idx_nxt_s   = {I_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == I_LAST) begin
                    state_nxt_s = ST_BUBBLE;
                end else begin
                    idx_nxt_s = idx_r + I_W'(1);
                end
            end
            ST_BUBBLE: begin
                if (stage_r == S_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                    stage_nxt_s = stage_r + STAGE_W'(1);
                    idx_nxt_s   = {I_W{1'b0}};
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                stage_nxt_s = {STAGE_W{1'b0}};
                idx_nxt_s   = {I_W{1'b0}};
            end
            default: begin
                state_nxt_s = ST_IDLE;
                stage_nxt_s = {STAGE_W{1'b0}};
                idx_nxt_s   = {I_W{1'b0}};
            end
        endcase
    end

    assign run_nxt_s = (state_nxt_s == ST_RUN);

    // Outputs are computed from next-state so they line up with the cycle the FSM is in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            rd_addr_a_r <= ADDR_ZERO;
            rd_addr_b_r <= ADDR_ZERO;
            tw_addr_r   <= TW_ZERO;
            wr_en_r     <= 1'b0;
            bf_enable_r <= 1'b0;
            wr_addr_a_r <= ADDR_ZERO;
            wr_addr_b_r <= ADDR_ZERO;
        end else begin
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
            rd_en_r     <= run_nxt_s;
            rd_addr_a_r <= run_nxt_s ? calc_addr_a(idx_nxt_s, stage_nxt_s) : ADDR_ZERO;
            rd_addr_b_r <= run_nxt_s ? calc_addr_b(calc_addr_a(idx_nxt_s, stage_nxt_s), stage_nxt_s)
                                     : ADDR_ZERO;
            tw_addr_r   <= run_nxt_s ? calc_tw(idx_nxt_s, stage_nxt_s) : TW_ZERO;
            wr_en_r     <= rd_en_r;
            bf_enable_r <= rd_en_r;
            wr_addr_a_r <= rd_en_r ? rd_addr_a_r : ADDR_ZERO;
            wr_addr_b_r <= rd_en_r ? rd_addr_b_r : ADDR_ZERO;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_en     = rd_en_r;
    assign rd_addr_a = rd_addr_a_r;
    assign rd_addr_b = rd_addr_b_r;
    assign tw_addr   = tw_addr_r;
    assign wr_en     = wr_en_r;
    assign bf_enable = bf_enable_r;
    assign wr_addr_a = wr_addr_a_r;
    assign wr_addr_b = wr_addr_b_r;
    assign stage     = stage_r;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen at N=8: per-cycle expected output vectors are queued from an
// arithmetic model when a transform is started, then popped and compared each cycle.
module tb_fft_addr_gen;

    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, rd_en, bf_enable, wr_en;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;
    logic [1:0] stage;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
        logic       wr_en;
        logic       bf;
        logic [2:0] wa;
        logic [2:0] wb;
        logic [1:0] stage;
    } vec_t;

    vec_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    fft_addr_gen #(.LOG2_N(LOG2_N)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr), .rd_en(rd_en),
        .bf_enable(bf_enable), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .stage(stage)
    );

    always #5 clk = ~clk;

    function automatic vec_t observe();
        return {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, bf_enable,
                wr_addr_a, wr_addr_b, stage};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent model: block-offset arithmetic rather than bit masks.
    task automatic push_transform();
        int   half;
        logic pe;
        logic [2:0] pa, pb;
        vec_t v;
        pe = 1'b0; pa = 3'd0; pb = 3'd0;
        for (int s = 0; s < LOG2_N; s++) begin
            half = 1 << s;
            for (int i = 0; i < N / 2; i++) begin
                v = '0;
                v.busy = 1'b1; v.rd_en = 1'b1;
                v.a  = 3'((i / half) * 2 * half + (i % half));
                v.b  = 3'((i / half) * 2 * half + (i % half) + half);
                v.tw = 2'((i % half) * ((N / 2) / half));
                v.wr_en = pe; v.bf = pe; v.wa = pa; v.wb = pb;
                v.stage = 2'(s);
                q.push_back(v);
                pe = 1'b1; pa = v.a; pb = v.b;
            end
            v = '0;
            v.busy = 1'b1; v.wr_en = 1'b1; v.bf = 1'b1; v.wa = pa; v.wb = pb; v.stage = 2'(s);
            q.push_back(v);
            pe = 1'b0; pa = 3'd0; pb = 3'd0;
        end
        v = '0; v.busy = 1'b1; v.done = 1'b1; v.stage = 2'(LOG2_N - 1);
        q.push_back(v);
        v = '0;
        q.push_back(v);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        vec_t exp_v;
        int   wr_count;
        int   done_cycle;
        int   n0, n1;

        // Reset held low with start high: everything quiet.
        reset = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 32'(observe()), 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        start = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        check("idle_after_release", 32'(observe()), 32'd0);

        // Full transform with a stray start pulse while busy.
        start = 1'b1;
        tick();
        start = 1'b0;
        push_transform();
        wr_count   = 0;
        done_cycle = -1;
        for (int c = 1; c <= 17; c++) begin
            exp_v = q.pop_front();
            check($sformatf("cycle%0d", c), 32'(observe()), 32'(exp_v));
            if (wr_en) wr_count++;
            if (done) done_cycle = c;
            if (c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
            if (c < 17) tick();
        end
        check("wr_count", 32'(wr_count), 32'd12);
        check("done_cycle", 32'(done_cycle), 32'd16);
        check("queue_empty", 32'(q.size()), 32'd0);

        // Reset in the middle of stage 1.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("mid_rd_en", {31'd0, rd_en}, 32'd1);
        check("mid_addr", {26'd0, rd_addr_a, rd_addr_b}, {26'd0, 3'd1, 3'd3});
        check("mid_stage", 32'(stage), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rd_en", {31'd0, rd_en}, 32'd0);
        check("async_wr_en", {31'd0, wr_en}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_after_mid_reset", {31'd0, busy}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_addr", {26'd0, rd_addr_a, rd_addr_b}, {26'd0, 3'd0, 3'd1});
        check("restart_stage", 32'(stage), 32'd0);

        // Continuous start: done period is LOG2_N*(N/2+1) + DONE + IDLE.
        start = 1'b1;
        wait_done(n0);
        tick();
        wait_done(n1);
        check("period1", 32'(n1 + 1), 32'd17);
        tick();
        wait_done(n1);
        check("period2", 32'(n1 + 1), 32'd17);
        start = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
